// File: rtl/des_core.sv
// des_core: single-block DES encrypt/decrypt engine.
// Key, mode and data are held in registers loaded by strobes. The key schedule and
// all 16 Feistel rounds are unrolled combinational logic behind those registers, so
// etxt is valid in the cycle right after a loading edge.
//
// Ports
//   ck     clock, all registers update on posedge
//   rst_n  asynchronous active-low reset
//   keyin  key load strobe, samples k and f
//   k      64-bit key, bit 63 = DES bit 1, parity bits ignored
//   datin  data load strobe, samples ptxt
//   ptxt   64-bit input block
//   f      mode, 1 = encrypt, 0 = decrypt
//   etxt   64-bit result block
//
// Probe nets: pc1, ks[1..16], ip[1..17], lr.
module des_core (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        keyin,
  input  logic [63:0] k,
  input  logic        datin,
  input  logic [63:0] ptxt,
  input  logic        f,
  output logic [63:0] etxt
);

  // Tables use DES numbering: entry value j selects DES bit j (bit 1 = MSB).
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Each S-box is stored row-major: index = {row, col} = {b1, b6, b2..b5}.
  localparam logic [3:0] SBOX [8][64] = '{
    '{4'd14, 4'd4, 4'd13, 4'd1, 4'd2, 4'd15, 4'd11, 4'd8, 4'd3, 4'd10, 4'd6, 4'd12, 4'd5, 4'd9, 4'd0, 4'd7,
      4'd0, 4'd15, 4'd7, 4'd4, 4'd14, 4'd2, 4'd13, 4'd1, 4'd10, 4'd6, 4'd12, 4'd11, 4'd9, 4'd5, 4'd3, 4'd8,
      4'd4, 4'd1, 4'd14, 4'd8, 4'd13, 4'd6, 4'd2, 4'd11, 4'd15, 4'd12, 4'd9, 4'd7, 4'd3, 4'd10, 4'd5, 4'd0,
      4'd15, 4'd12, 4'd8, 4'd2, 4'd4, 4'd9, 4'd1, 4'd7, 4'd5, 4'd11, 4'd3, 4'd14, 4'd10, 4'd0, 4'd6, 4'd13},
    '{4'd15, 4'd1, 4'd8, 4'd14, 4'd6, 4'd11, 4'd3, 4'd4, 4'd9, 4'd7, 4'd2, 4'd13, 4'd12, 4'd0, 4'd5, 4'd10,
      4'd3, 4'd13, 4'd4, 4'd7, 4'd15, 4'd2, 4'd8, 4'd14, 4'd12, 4'd0, 4'd1, 4'd10, 4'd6, 4'd9, 4'd11, 4'd5,
      4'd0, 4'd14, 4'd7, 4'd11, 4'd10, 4'd4, 4'd13, 4'd1, 4'd5, 4'd8, 4'd12, 4'd6, 4'd9, 4'd3, 4'd2, 4'd15,
      4'd13, 4'd8, 4'd10, 4'd1, 4'd3, 4'd15, 4'd4, 4'd2, 4'd11, 4'd6, 4'd7, 4'd12, 4'd0, 4'd5, 4'd14, 4'd9},
    '{4'd10, 4'd0, 4'd9, 4'd14, 4'd6, 4'd3, 4'd15, 4'd5, 4'd1, 4'd13, 4'd12, 4'd7, 4'd11, 4'd4, 4'd2, 4'd8,
      4'd13, 4'd7, 4'd0, 4'd9, 4'd3, 4'd4, 4'd6, 4'd10, 4'd2, 4'd8, 4'd5, 4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
      4'd13, 4'd6, 4'd4, 4'd9, 4'd8, 4'd15, 4'd3, 4'd0, 4'd11, 4'd1, 4'd2, 4'd12, 4'd5, 4'd10, 4'd14, 4'd7,
      4'd1, 4'd10, 4'd13, 4'd0, 4'd6, 4'd9, 4'd8, 4'd7, 4'd4, 4'd15, 4'd14, 4'd3, 4'd11, 4'd5, 4'd2, 4'd12},
    '{4'd7, 4'd13, 4'd14, 4'd3, 4'd0, 4'd6, 4'd9, 4'd10, 4'd1, 4'd2, 4'd8, 4'd5, 4'd11, 4'd12, 4'd4, 4'd15,
      4'd13, 4'd8, 4'd11, 4'd5, 4'd6, 4'd15, 4'd0, 4'd3, 4'd4, 4'd7, 4'd2, 4'd12, 4'd1, 4'd10, 4'd14, 4'd9,
      4'd10, 4'd6, 4'd9, 4'd0, 4'd12, 4'd11, 4'd7, 4'd13, 4'd15, 4'd1, 4'd3, 4'd14, 4'd5, 4'd2, 4'd8, 4'd4,
      4'd3, 4'd15, 4'd0, 4'd6, 4'd10, 4'd1, 4'd13, 4'd8, 4'd9, 4'd4, 4'd5, 4'd11, 4'd12, 4'd7, 4'd2, 4'd14},
    '{4'd2, 4'd12, 4'd4, 4'd1, 4'd7, 4'd10, 4'd11, 4'd6, 4'd8, 4'd5, 4'd3, 4'd15, 4'd13, 4'd0, 4'd14, 4'd9,
      4'd14, 4'd11, 4'd2, 4'd12, 4'd4, 4'd7, 4'd13, 4'd1, 4'd5, 4'd0, 4'd15, 4'd10, 4'd3, 4'd9, 4'd8, 4'd6,
      4'd4, 4'd2, 4'd1, 4'd11, 4'd10, 4'd13, 4'd7, 4'd8, 4'd15, 4'd9, 4'd12, 4'd5, 4'd6, 4'd3, 4'd0, 4'd14,
      4'd11, 4'd8, 4'd12, 4'd7, 4'd1, 4'd14, 4'd2, 4'd13, 4'd6, 4'd15, 4'd0, 4'd9, 4'd10, 4'd4, 4'd5, 4'd3},
    '{4'd12, 4'd1, 4'd10, 4'd15, 4'd9, 4'd2, 4'd6, 4'd8, 4'd0, 4'd13, 4'd3, 4'd4, 4'd14, 4'd7, 4'd5, 4'd11,
      4'd10, 4'd15, 4'd4, 4'd2, 4'd7, 4'd12, 4'd9, 4'd5, 4'd6, 4'd1, 4'd13, 4'd14, 4'd0, 4'd11, 4'd3, 4'd8,
      4'd9, 4'd14, 4'd15, 4'd5, 4'd2, 4'd8, 4'd12, 4'd3, 4'd7, 4'd0, 4'd4, 4'd10, 4'd1, 4'd13, 4'd11, 4'd6,
      4'd4, 4'd3, 4'd2, 4'd12, 4'd9, 4'd5, 4'd15, 4'd10, 4'd11, 4'd14, 4'd1, 4'd7, 4'd6, 4'd0, 4'd8, 4'd13},
    '{4'd4, 4'd11, 4'd2, 4'd14, 4'd15, 4'd0, 4'd8, 4'd13, 4'd3, 4'd12, 4'd9, 4'd7, 4'd5, 4'd10, 4'd6, 4'd1,
      4'd13, 4'd0, 4'd11, 4'd7, 4'd4, 4'd9, 4'd1, 4'd10, 4'd14, 4'd3, 4'd5, 4'd12, 4'd2, 4'd15, 4'd8, 4'd6,
      4'd1, 4'd4, 4'd11, 4'd13, 4'd12, 4'd3, 4'd7, 4'd14, 4'd10, 4'd15, 4'd6, 4'd8, 4'd0, 4'd5, 4'd9, 4'd2,
      4'd6, 4'd11, 4'd13, 4'd8, 4'd1, 4'd4, 4'd10, 4'd7, 4'd9, 4'd5, 4'd0, 4'd15, 4'd14, 4'd2, 4'd3, 4'd12},
    '{4'd13, 4'd2, 4'd8, 4'd4, 4'd6, 4'd15, 4'd11, 4'd1, 4'd10, 4'd9, 4'd3, 4'd14, 4'd5, 4'd0, 4'd12, 4'd7,
      4'd1, 4'd15, 4'd13, 4'd8, 4'd10, 4'd3, 4'd7, 4'd4, 4'd12, 4'd5, 4'd6, 4'd11, 4'd0, 4'd14, 4'd9, 4'd2,
      4'd7, 4'd11, 4'd4, 4'd1, 4'd9, 4'd12, 4'd14, 4'd2, 4'd0, 4'd6, 4'd10, 4'd13, 4'd15, 4'd3, 4'd5, 4'd8,
      4'd2, 4'd1, 4'd14, 4'd7, 4'd4, 4'd10, 4'd8, 4'd13, 4'd15, 4'd12, 4'd9, 4'd0, 4'd3, 4'd5, 4'd6, 4'd11}
  };

  function automatic logic [63:0] ip_f(input logic [63:0] v);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = v[6'(64 - IP_T[6'(i)])];
    return o;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] v);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = v[6'(64 - FP_T[6'(i)])];
    return o;
  endfunction

  function automatic logic [47:0] e_f(input logic [31:0] v);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = v[5'(32 - E_T[6'(i)])];
    return o;
  endfunction

  function automatic logic [31:0] p_f(input logic [31:0] v);
    logic [31:0] o;
    for (int i = 0; i < 32; i++) o[5'(31 - i)] = v[5'(32 - P_T[5'(i)])];
    return o;
  endfunction

  function automatic logic [55:0] pc1_f(input logic [63:0] v);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[6'(55 - i)] = v[6'(64 - PC1_T[6'(i)])];
    return o;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] v);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = v[6'(56 - PC2_T[6'(i)])];
    return o;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] sk);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  six;
    x = e_f(r) ^ sk;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = x[6'(47 - 6 * b) -: 6];
      // Row is the outer bit pair, column the inner four.
      s[5'(31 - 4 * b) -: 4] = SBOX[3'(b)][{six[5], six[0], six[4:1]}];
    end
    return p_f(s);
  endfunction

  logic [63:0] key_q, key_d;
  logic [63:0] data_q, data_d;
  logic        mode_q, mode_d;

  always_comb begin
    key_d  = keyin ? k : key_q;
    mode_d = keyin ? f : mode_q;
    data_d = datin ? ptxt : data_q;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      key_q  <= '0;
      mode_q <= 1'b1;
      data_q <= '0;
    end else begin
      key_q  <= key_d;
      mode_q <= mode_d;
      data_q <= data_d;
    end
  end

  // Key schedule
  logic [55:0] pc1;
  logic [27:0] c [0:16];
  logic [27:0] d [0:16];
  logic [47:0] ks [1:16];

  always_comb begin
    pc1  = pc1_f(key_q);
    c[0] = pc1[55:28];
    d[0] = pc1[27:0];
    for (int n = 1; n <= 16; n++) begin
      if (n == 1 || n == 2 || n == 9 || n == 16) begin
        c[5'(n)] = {c[5'(n - 1)][26:0], c[5'(n - 1)][27]};
        d[5'(n)] = {d[5'(n - 1)][26:0], d[5'(n - 1)][27]};
      end else begin
        c[5'(n)] = {c[5'(n - 1)][25:0], c[5'(n - 1)][27:26]};
        d[5'(n)] = {d[5'(n - 1)][25:0], d[5'(n - 1)][27:26]};
      end
      ks[5'(n)] = pc2_f({c[5'(n)], d[5'(n)]});
    end
  end

  // Feistel datapath; decrypt simply walks the subkeys in reverse order.
  logic [63:0] ip [1:17];
  logic [47:0] sk [1:16];
  logic [63:0] lr;

  always_comb begin
    ip[1] = ip_f(data_q);
    for (int n = 1; n <= 16; n++) begin
      sk[5'(n)]     = mode_q ? ks[5'(n)] : ks[5'(17 - n)];
      ip[5'(n + 1)] = {ip[5'(n)][31:0],
                       ip[5'(n)][63:32] ^ feistel(ip[5'(n)][31:0], sk[5'(n)])};
    end
    lr   = {ip[17][31:0], ip[17][63:32]};
    etxt = fp_f(lr);
  end

endmodule

// File: tb/tb_des_core.sv
// Bench for des_core: directed known-answer vectors, reset behaviour, strobe
// independence, and random blocks compared against a bit-numbered DES model.
module tb_des_core;

  logic        ck = 1'b0;
  logic        rst_n = 1'b1;
  logic        keyin = 1'b0;
  logic        datin = 1'b0;
  logic        f = 1'b0;
  logic [63:0] k = '0;
  logic [63:0] ptxt = '0;
  logic [63:0] etxt;

  int total = 0;
  int bad = 0;

  // Register image tracked by the bench from what it drives.
  logic [63:0] m_key = '0;
  logic [63:0] m_data = '0;
  bit          m_mode = 1'b1;

  des_core dut (
    .ck(ck), .rst_n(rst_n), .keyin(keyin), .k(k),
    .datin(datin), .ptxt(ptxt), .etxt(etxt), .f(f)
  );

  always #5 ck = ~ck;

  int t_ip[$] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                  62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                  57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                  61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int t_fp[$] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                  38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                  36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                  34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  int t_e[$] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int t_p[$] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int t_pc1[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                   19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                   14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int t_pc2[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                   41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int t_s[$] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // Output bit i (DES numbering, MSB first) takes input bit t[i] of a win-bit vector.
  function automatic logic [63:0] perm(input logic [63:0] v, input int win, input int t[$]);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < t.size(); i++) o = (o << 1) | ((v >> (win - t[i])) & 64'd1);
    return o;
  endfunction

  function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] sk);
    logic [63:0] e;
    logic [47:0] x;
    logic [63:0] s;
    int six, row, col;
    e = perm({32'd0, r}, 32, t_e);
    x = e[47:0] ^ sk;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = int'((x >> (42 - 6 * b)) & 48'd63);
      row = ((six >> 4) & 2) | (six & 1);
      col = (six >> 1) & 15;
      s = (s << 4) | 64'(t_s[b * 64 + row * 16 + col]);
    end
    e = perm(s, 32, t_p);
    return e[31:0];
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk, input bit enc);
    logic [63:0] cd;
    logic [27:0] c, d;
    logic [47:0] sub [16];
    logic [63:0] x;
    logic [31:0] l, r, t;
    int sh;
    cd = perm(key, 64, t_pc1);
    c = cd[55:28];
    d = cd[27:0];
    for (int n = 0; n < 16; n++) begin
      sh = (n == 0 || n == 1 || n == 8 || n == 15) ? 1 : 2;
      for (int j = 0; j < sh; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      x = perm({8'd0, c, d}, 56, t_pc2);
      sub[n] = x[47:0];
    end
    x = perm(blk, 64, t_ip);
    l = x[63:32];
    r = x[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_ref(r, enc ? sub[i] : sub[15 - i]);
      l = t;
    end
    return perm({r, l}, 64, t_fp);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One-cycle strobe pulse; unloaded inputs carry junk to show they are ignored.
  task automatic strobe(input bit ld_key, input bit ld_dat, input logic [63:0] kv,
                        input bit fv, input logic [63:0] pv);
    @(negedge ck);
    keyin = ld_key;
    datin = ld_dat;
    k     = ld_key ? kv : rnd64();
    f     = ld_key ? fv : 1'($urandom);
    ptxt  = ld_dat ? pv : rnd64();
    @(posedge ck);
    #1;
    keyin = 1'b0;
    datin = 1'b0;
    if (ld_key) begin
      m_key  = kv;
      m_mode = fv;
    end
    if (ld_dat) m_data = pv;
  endtask

  localparam logic [63:0] RST_CT = 64'h8CA64DE9C1B123A7;

  initial begin
    logic [63:0] kk, pt, ct;
    bit          md;

    // Reset
    #2 rst_n = 1'b0;
    repeat (2) @(posedge ck);
    #1 check("reset_held", etxt, RST_CT);
    @(negedge ck) rst_n = 1'b1;
    repeat (2) @(posedge ck);
    #1 check("reset_release", etxt, RST_CT);

    // FIPS worked example
    strobe(1, 0, 64'h133457799BBCDFF1, 1'b1, '0);
    check("pc1_probe", 64'(dut.pc1), 64'h00F0CCAAF556678F);
    check("ks01_probe", 64'(dut.ks[1]), 64'h00001B02EFFC7072);
    strobe(0, 1, '0, 1'b0, 64'h0123456789ABCDEF);
    check("ip1_probe", dut.ip[1], 64'hCC00CCFFF0AAF0AA);
    check("enc_fips", etxt, 64'h85E813540F0AB405);

    // Asynchronous reset between edges
    @(negedge ck);
    #2 rst_n = 1'b0;
    #1 check("async_reset", etxt, RST_CT);
    #1 rst_n = 1'b1;
    m_key = '0; m_data = '0; m_mode = 1'b1;
    @(posedge ck);
    #1 check("post_reset_idle", etxt, RST_CT);

    // Decrypt the worked example
    strobe(1, 0, 64'h133457799BBCDFF1, 1'b0, '0);
    strobe(0, 1, '0, 1'b0, 64'h85E813540F0AB405);
    check("dec_fips", etxt, 64'h0123456789ABCDEF);

    // Published known-answer vectors
    strobe(1, 1, 64'h0E329232EA6D0D73, 1'b1, 64'h8787878787878787);
    check("kat_0e32", etxt, 64'h0000000000000000);
    strobe(1, 1, 64'h0101010101010101, 1'b1, 64'h8000000000000000);
    check("kat_weak_enc", etxt, 64'h95F8A5E5DD31D900);
    strobe(1, 0, 64'h0101010101010101, 1'b0, '0);
    check("kat_weak_dec", etxt, 64'h95F8A5E5DD31D900);

    // Round trip with the given vector
    strobe(1, 0, 64'hDAB783857DCED3C8, 1'b1, '0);
    strobe(0, 1, '0, 1'b0, 64'h2ECEA62A2ECEA62A);
    check("rt_given_enc", etxt, des_ref(64'hDAB783857DCED3C8, 64'h2ECEA62A2ECEA62A, 1'b1));
    ct = etxt;
    strobe(1, 1, 64'hDAB783857DCED3C8, 1'b0, ct);
    check("rt_given_dec", etxt, 64'h2ECEA62A2ECEA62A);

    // Random round trips, both strobes on the same edge for the decrypt
    for (int i = 0; i < 3; i++) begin
      kk = (i == 0) ? 64'hDAB783857DCED3C8 : rnd64();
      pt = rnd64();
      strobe(1, 1, kk, 1'b1, pt);
      check("rt_rand_enc", etxt, des_ref(kk, pt, 1'b1));
      ct = etxt;
      strobe(1, 1, kk, 1'b0, ct);
      check("rt_rand_dec", etxt, pt);
    end

    // Key-only reload re-evaluates the held data, then data-only reload
    for (int i = 0; i < 3; i++) begin
      kk = rnd64();
      md = 1'($urandom);
      strobe(1, 0, kk, md, '0);
      check("key_only_reload", etxt, des_ref(m_key, m_data, m_mode));
      pt = rnd64();
      strobe(0, 1, '0, 1'b0, pt);
      check("data_only_reload", etxt, des_ref(m_key, m_data, m_mode));
    end

    // Strobes held for several cycles with stable inputs
    kk = rnd64();
    pt = rnd64();
    @(negedge ck);
    keyin = 1'b1; datin = 1'b1; k = kk; f = 1'b1; ptxt = pt;
    m_key = kk; m_mode = 1'b1; m_data = pt;
    for (int i = 0; i < 3; i++) begin
      @(posedge ck);
      #1 check("held_strobe", etxt, des_ref(kk, pt, 1'b1));
    end
    @(negedge ck);
    keyin = 1'b0; datin = 1'b0;

    // Random mixed traffic against the model
    for (int i = 0; i < 8; i++) begin
      kk = rnd64();
      pt = rnd64();
      md = 1'($urandom);
      strobe(1, 1, kk, md, pt);
      check("random_model", etxt, des_ref(kk, pt, md));
    end

    // Idle cycles keep the last result
    repeat (3) @(posedge ck);
    #1 check("idle_hold", etxt, des_ref(m_key, m_data, m_mode));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
